// File: rtl/synchronous_fifo_if.sv
// ============================================================================
//  Module      : fifo_if
//  Description : Producer/consumer bundle for synchronous_fifo. Carries write
//                data and request, read request, registered read data and
//                the full/empty status. When SYNC_FIFO_ERR_EN is defined the
//                sticky overflow/underflow flags are carried as well.
//  Modports    : master - producer/consumer side (drives din/write_en/read_en)
//                slave  - FIFO side (drives dout/empty/full[/overflow/underflow])
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din;
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
`ifdef SYNC_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, write_en, read_en,
    input  dout, empty, full, overflow, underflow
  );

  modport slave (
    input  din, write_en, read_en,
    output dout, empty, full, overflow, underflow
  );
`else
  modport master (
    output din, write_en, read_en,
    input  dout, empty, full
  );

  modport slave (
    input  din, write_en, read_en,
    output dout, empty, full
  );
`endif
endinterface

`default_nettype wire

// File: rtl/synchronous_fifo.sv
// ============================================================================
//  Module      : synchronous_fifo
//  Description : Single-clock FIFO with DATA_DEPTH x DATA_WIDTH register
//                storage, registered read data and full/empty flags decoded
//                from wrap-bit extended pointers.
//  Ports       : clk   - single clock, rising edge
//                reset - asynchronous, active-low reset
//                bus   - fifo_if.slave (din, write_en, read_en, dout,
//                        empty, full [, overflow, underflow])
//  Options     : SYNC_FIFO_ERR_EN - adds sticky overflow/underflow outputs
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronous_fifo #(
  parameter int DATA_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire    clk,
  input  wire    reset,
  fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DATA_DEPTH);
  localparam logic [ADDR_W:0] c_ptr_one = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [ADDR_W:0]       r_wr_ptr;
  logic [ADDR_W:0]       r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Same index with the same lap means nothing stored; same index one lap
  // apart means every entry is occupied.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // Acceptance uses only the registered flags, so a read in the same cycle
  // never lets a write into a full FIFO and vice versa.
  assign w_wr_acc = bus.write_en && !w_full;
  assign w_rd_acc = bus.read_en  && !w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_dout   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // Storage is deliberately left out of reset; stale contents are unreachable
  // once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.din;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.write_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.read_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_synchronous_fifo.sv
// ============================================================================
//  Module      : tb_synchronous_fifo
//  Description : Self-checking bench for synchronous_fifo. A queue-based
//                reference model tracks contents, read data and sticky error
//                flags; a compare process checks every falling edge, and
//                directed sequences pin literal expectations.
//  Options     : SYNC_FIFO_ERR_EN - also checks overflow/underflow
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_synchronous_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_if #(.DATA_WIDTH(WIDTH)) fif ();

  synchronous_fifo #(
    .DATA_DEPTH (DEPTH),
    .DATA_WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model: contents as a queue, plus last read word and flags.
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf  = 1'b0;
  bit               m_unf  = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      bit was_full;
      bit was_empty;
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (fif.write_en && was_full)  m_ovf = 1'b1;
      if (fif.read_en  && was_empty) m_unf = 1'b1;
      if (fif.read_en && !was_empty) m_dout = m_q.pop_front();
      if (fif.write_en && !was_full) m_q.push_back(fif.din);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_empty", {31'd0, fif.empty}, {31'd0, m_q.size() == 0});
      check("cmp_full",  {31'd0, fif.full},  {31'd0, m_q.size() == DEPTH});
      check("cmp_dout",  fif.dout, m_dout);
`ifdef SYNC_FIFO_ERR_EN
      check("cmp_overflow",  {31'd0, fif.overflow},  {31'd0, m_ovf});
      check("cmp_underflow", {31'd0, fif.underflow}, {31'd0, m_unf});
`endif
    end
  end

  // Drive one cycle of requests, then return just after the rising edge.
  task automatic step(input bit we, input bit re, input logic [WIDTH-1:0] d);
    @(negedge clk);
    fif.write_en = we;
    fif.read_en  = re;
    fif.din      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_seq [$];
    fif.write_en = 1'b0;
    fif.read_en  = 1'b0;
    fif.din      = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step(1'b0, 1'b0, '0);
    check("reset_empty", {31'd0, fif.empty}, 32'd1);
    check("reset_full",  {31'd0, fif.full},  32'd0);
    check("reset_dout",  fif.dout, 32'd0);

    // Fill, then one dropped write
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'h11111111 * i);
    check("fill_full",  {31'd0, fif.full},  32'd1);
    check("fill_empty", {31'd0, fif.empty}, 32'd0);
    step(1'b1, 1'b0, 32'hDEADBEEF);
    check("ovf_still_full", {31'd0, fif.full}, 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_flag", {31'd0, fif.overflow}, 32'd1);
`endif

    // Drain, then one ignored read
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      check("drain_dout", fif.dout, 32'h11111111 * i);
    end
    check("drain_empty", {31'd0, fif.empty}, 32'd1);
    step(1'b0, 1'b1, '0);
    check("unf_dout_hold", fif.dout, 32'h88888888);
`ifdef SYNC_FIFO_ERR_EN
    check("unf_flag", {31'd0, fif.underflow}, 32'd1);
`endif

    // Wrap-around
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h50 + i);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, '0);
      check("wrap_pre_dout", fif.dout, 32'h50 + i);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'hA0 + i);
      check("wrap_full_timing", {31'd0, fif.full}, (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      check("wrap_dout", fif.dout, 32'hA0 + i);
    end
    check("wrap_empty", {31'd0, fif.empty}, 32'd1);

    // Simultaneous read/write with 3 words stored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hB0 + i);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'hB3 + i);
      check("simul_dout", fif.dout, 32'hB0 + i);
      check("simul_occ", m_q.size(), 32'd3);
    end
    check("simul_not_empty", {31'd0, fif.empty}, 32'd0);
    // Fill to full, then simultaneous: read accepted, write dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hC0 + i);
    check("simul_full", {31'd0, fif.full}, 32'd1);
    step(1'b1, 1'b1, 32'hDEAD0000);
    check("simul_full_dout", fif.dout, 32'hB4);
    check("simul_full_after", {31'd0, fif.full}, 32'd0);
    check("simul_full_occ", m_q.size(), 32'd7);
    exp_seq = '{32'hB5, 32'hB6, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
    foreach (exp_seq[k]) begin
      step(1'b0, 1'b1, '0);
      check("simul_drain", fif.dout, exp_seq[k]);
    end

    // Mid-operation reset with 4 words stored
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hD0 + i);
    fif.write_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_empty", {31'd0, fif.empty}, 32'd1);
    check("mrst_full",  {31'd0, fif.full},  32'd0);
    check("mrst_dout",  fif.dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'hE1E1E1E1);
    step(1'b0, 1'b1, '0);
    check("mrst_new_word", fif.dout, 32'hE1E1E1E1);
    check("mrst_empty_after", {31'd0, fif.empty}, 32'd1);

    // Randomized traffic with shifting write/read bias
    for (int p = 0; p < 4; p++) begin
      int wb;
      int rb;
      wb = (p == 0) ? 80 : (p == 1) ? 30 : 55;
      rb = (p == 0) ? 30 : (p == 1) ? 80 : 55;
      for (int n = 0; n < 500; n++) begin
        step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, $urandom);
      end
    end

    step(1'b0, 1'b0, '0);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
